capture_reader: RTL and testbench

CAPTURE_READER -- requirements
Module: capture_reader

---
 rtl/capture_reader.sv | 122 ++++++++++++
 tb/tb_capture_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_reader.sv
// Drains a paused capture FIFO into an MSB-first AXI-Stream-style byte stream.
// Optional header bytes in front of each drain: define CAPTURE_READER_HDR_EN.
module capture_reader #(
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  HDR_BYTE0 = 8'hA5,
  parameter logic [7:0]  HDR_BYTE1 = 8'h5A
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arm,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic [3:0]        state
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_FETCH = 4'b0010;
  localparam logic [3:0] S_LATCH = 4'b0100;
  localparam logic [3:0] S_SEND  = 4'b1000;
`ifdef CAPTURE_READER_HDR_EN
  localparam logic [3:0] S_HDR   = 4'b1001;
`endif

  logic [3:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q doubles as the header byte index while in HDR
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arm && !fifo_empty) begin
`ifdef CAPTURE_READER_HDR_EN
          state_d = S_HDR;
          cnt_d   = '0;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef CAPTURE_READER_HDR_EN
      S_HDR: begin
        if (m_tready) begin
          if (cnt_q[0]) begin
            state_d = fifo_empty ? S_IDLE : S_FETCH;
            cnt_d   = '0;
          end else begin
            cnt_d = CNT_W'(1);
          end
        end
      end
`endif
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        shreg_d = fifo_dout;
        cnt_d   = CNT_W'(NB - 1);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (m_tready) begin
          if (cnt_q == '0) begin
            state_d = fifo_empty ? S_IDLE : S_FETCH;
          end else begin
            shreg_d = shreg_q << 8;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = 8'h00;
    m_tlast    = 1'b0;
    busy       = (state_q != S_IDLE);
    state      = state_q;
    case (state_q)
      // gate on empty so a read can never be issued against an empty FIFO
      S_FETCH: fifo_rd_en = !fifo_empty;
      S_SEND: begin
        m_tvalid = 1'b1;
        m_tdata  = shreg_q[DATA_W-1 -: 8];
        m_tlast  = (cnt_q == '0) && fifo_empty;
      end
`ifdef CAPTURE_READER_HDR_EN
      S_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = cnt_q[0] ? HDR_BYTE1 : HDR_BYTE0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_capture_reader.sv
// Scoreboard bench for capture_reader: FIFO model, random/directed drains, reset mid-send.
module tb_capture_reader;

  localparam int DATA_W = 16;
`ifdef CAPTURE_READER_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn, arm, m_tready;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty, fifo_rd_en, m_tvalid, m_tlast, busy;
  logic [7:0]        m_tdata;
  logic [3:0]        state;

  capture_reader #(.DATA_W(DATA_W), .HDR_BYTE0(8'hA5), .HDR_BYTE1(8'h5A)) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // FIFO model: stimulus owns wr_ptr, the read process owns rd_ptr
  logic [DATA_W-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Scoreboard: stimulus owns exp_wr, monitor owns exp_rd
  logic [7:0] exp_d [0:1023];
  bit         exp_l [0:1023];
  int         exp_g [0:1023];
  int exp_wr = 0;
  int exp_rd = 0;
  int checks = 0;
  int errors = 0;
  int tmo = 0;
  int fin_req = 0;
  int fin_ack = 0;
  bit tput = 1'b0;
  bit idle_chk = 1'b0;
  logic [DATA_W-1:0] bq [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  bit         prstn = 1'b1;
  bit         pstall = 1'b0;
  bit         pidle = 1'b0;
  logic [7:0] pdata;
  logic       plast;
  int         since = 0;

  always @(negedge clk) begin
    since++;
    if (!prstn) begin
      chk("rst_state", 32'(state), 32'h1);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
      chk("rst_tvalid", 32'(m_tvalid), 32'h0);
      chk("rst_tlast", 32'(m_tlast), 32'h0);
      chk("rst_tdata", 32'(m_tdata), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    if (rstn) begin
      chk("state_legal", 32'(state == 4'b0001 || state == 4'b0010 || state == 4'b0100 ||
                             state == 4'b1000 || (HDR && state == 4'b1001)), 32'h1);
      if (fifo_rd_en) chk("rd_en_nonempty", 32'(fifo_empty), 32'h0);
      if (idle_chk) begin
        chk("idle_state", 32'(state), 32'h1);
        chk("idle_rd_en", 32'(fifo_rd_en), 32'h0);
      end
      if (pstall && prstn) begin
        chk("stall_tvalid", 32'(m_tvalid), 32'h1);
        chk("stall_tdata", 32'(m_tdata), 32'(pdata));
        chk("stall_tlast", 32'(m_tlast), 32'(plast));
      end
      if (pidle && prstn) chk("busy_after_last", 32'(busy), 32'h0);
      pidle = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_rd >= exp_wr) begin
          chk("unexpected_byte", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          chk("tdata", 32'(m_tdata), 32'(exp_d[exp_rd[9:0]]));
          chk("tlast", 32'(m_tlast), 32'(exp_l[exp_rd[9:0]]));
          if (tput && exp_g[exp_rd[9:0]] != 0) chk("gap_cycles", 32'(since), 32'(exp_g[exp_rd[9:0]]));
          exp_rd++;
        end
        pidle = m_tlast;
        since = 0;
      end
    end else begin
      pidle = 1'b0;
    end
    if (fin_req != fin_ack) begin
      chk("drained", 32'(exp_rd), 32'(exp_wr));
      chk("timeouts", 32'(tmo), 32'h0);
      fin_ack = fin_req;
    end
    pstall = rstn && m_tvalid && !m_tready;
    pdata  = m_tdata;
    plast  = m_tlast;
    prstn  = rstn;
  end

  task automatic exp_push(input logic [7:0] d, input bit l, input int g);
    exp_d[exp_wr[9:0]] = d;
    exp_l[exp_wr[9:0]] = l;
    exp_g[exp_wr[9:0]] = g;
    exp_wr++;
  endtask

  task automatic push_hdr();
    if (HDR) begin
      exp_push(8'hA5, 1'b0, 0);
      exp_push(8'h5A, 1'b0, 1);
    end
  endtask

  task automatic wait_drain(input int start, input int mode, input bit drop);
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      if (drop && exp_rd > start) arm = 1'b0;
      if (mode == 1) m_tready = ~m_tready;
      else if (mode == 2) m_tready = 1'($urandom_range(0, 1));
      if (exp_rd == exp_wr && !busy && fifo_empty) done = 1'b1;
    end
    if (!done) tmo++;
  endtask

  // mode 0: ready held high, 1: ready toggling 1-0-1-0, 2: random ready
  task automatic run_batch(input int mode, input bit drop);
    int start = exp_wr;
    int n = bq.size();
    push_hdr();
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = bq[i];
      wr_ptr++;
      exp_push(bq[i][15:8], 1'b0, (i == 0 && !HDR) ? 0 : 3);
      exp_push(bq[i][7:0], i == n - 1, 1);
    end
    tput = (mode == 0);
    m_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    arm = 1'b1;
    wait_drain(start, mode, drop);
    arm = 1'b0;
    tput = 1'b0;
    m_tready = 1'b1;
    bq.delete();
    fin_req++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    bq = '{16'h1234, 16'hABCD};
    run_batch(0, 1'b0);
    bq = '{16'h1234, 16'hABCD};
    run_batch(1, 1'b0);

    arm = 1'b1; idle_chk = 1'b1;
    repeat (20) @(posedge clk);
    #1 idle_chk = 1'b0; arm = 1'b0;

    bq = '{16'h0001};
    run_batch(0, 1'b0);

    repeat (3) bq.push_back(16'($urandom));
    run_batch(0, 1'b1);

    // reset while byte 34 is presented: it must be dropped, then ABCD drains
    begin
      bit found = 1'b0;
      int start = exp_wr;
      push_hdr();
      exp_push(8'h12, 1'b0, 0);
      mem[wr_ptr[7:0]] = 16'h1234; wr_ptr++;
      mem[wr_ptr[7:0]] = 16'hABCD; wr_ptr++;
      m_tready = 1'b1; arm = 1'b1;
      for (int k = 0; k < 100 && !found; k++) begin
        @(posedge clk); #1;
        if (state == 4'b1000 && m_tdata == 8'h34) begin
          m_tready = 1'b0;
          found = 1'b1;
        end
      end
      if (!found) tmo++;
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      push_hdr();
      exp_push(8'hAB, 1'b0, 0);
      exp_push(8'hCD, 1'b1, 1);
      m_tready = 1'b1;
      wait_drain(start, 0, 1'b0);
      arm = 1'b0;
      fin_req++;
      repeat (3) @(posedge clk);
      #1;
    end

    for (int b = 0; b < 6; b++) begin
      int n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) bq.push_back(16'($urandom));
      run_batch($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
